// File: rtl/ariane_pkg.sv
// Shared core package slice: decoded instruction record and decoded-queue sizing.
package ariane_pkg;

  localparam int unsigned DECODED_QUEUE_DEPTH    = 4;
  localparam int unsigned DECODED_QUEUE_CF_LIMIT = 1;

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
    logic        use_pc;
    logic        is_compressed;
  } scoreboard_entry_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for a power-of-two circular buffer.
// Flush has priority and clears everything the following cycle.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers/count; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/decoded_instr_queue.sv
// Decoded instruction queue between decode and issue.
// Throttles decode once CF_LIMIT control-flow entries are resident.
// Optional zero-latency bypass when empty: define DECODED_QUEUE_FALLTHROUGH_EN.
module decoded_instr_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH    = DECODED_QUEUE_DEPTH,
  parameter int unsigned CF_LIMIT = DECODED_QUEUE_CF_LIMIT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     decoded_valid_i,
  input  scoreboard_entry_t        decoded_instr_i,
  input  logic                     is_ctrl_flow_i,
  output logic                     decoded_ack_o,
  output logic                     issue_valid_o,
  output scoreboard_entry_t        issue_instr_o,
  output logic                     issue_is_ctrl_flow_o,
  input  logic                     issue_ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   cf_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  scoreboard_entry_t mem_q    [DEPTH];
  logic [DEPTH-1:0]  cf_mem_q;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic [CNT_W-1:0] cf_q, cf_d;
  logic             cf_full;
  logic             push, bypass, fifo_push, fifo_pop;
  logic             head_cf;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) i_ptr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign cf_full = (cf_q == CNT_W'(CF_LIMIT));
  assign head_cf = cf_mem_q[rd_ptr];

  // Acceptance never looks at issue_ack_i; rst_ni gating keeps ack low during reset.
  assign decoded_ack_o = rst_ni && !flush_i && !full && !(is_ctrl_flow_i && cf_full);
  assign push          = decoded_valid_i && decoded_ack_o;

`ifdef DECODED_QUEUE_FALLTHROUGH_EN
  assign bypass = empty && push;
`else
  assign bypass = 1'b0;
`endif

  // Head presentation, either from storage or straight from decode when bypassing.
  always_comb begin
    issue_valid_o        = (!empty && !flush_i) || bypass;
    issue_instr_o        = mem_q[rd_ptr];
    issue_is_ctrl_flow_o = head_cf;
    if (bypass) begin
      issue_instr_o        = decoded_instr_i;
      issue_is_ctrl_flow_o = is_ctrl_flow_i;
    end
  end

  // A bypassed entry that is consumed immediately never touches storage.
  assign fifo_pop  = !empty && !flush_i && issue_ack_i;
  assign fifo_push = push && !(bypass && issue_ack_i);

  // Control-flow occupancy next state.
  always_comb begin
    cf_d = cf_q;
    if (flush_i) begin
      cf_d = '0;
    end else begin
      case ({fifo_push && is_ctrl_flow_i, fifo_pop && head_cf})
        2'b10:   cf_d = cf_q + CNT_W'(1);
        2'b01:   cf_d = cf_q - CNT_W'(1);
        default: cf_d = cf_q;
      endcase
    end
  end

  // Control-flow counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cf_q <= '0;
    else         cf_q <= cf_d;
  end

  // Storage array; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      mem_q[wr_ptr]    <= decoded_instr_i;
      cf_mem_q[wr_ptr] <= is_ctrl_flow_i;
    end
  end

  assign count_o    = count;
  assign cf_count_o = cf_q;

  a_count_le_depth : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CNT_W'(DEPTH));
  a_cf_le_count : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cf_q <= count);
  a_cf_le_limit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cf_q <= CNT_W'(CF_LIMIT));

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue (DEPTH=4, CF_LIMIT=1).
module tb_decoded_instr_queue;
  import ariane_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              dv;
  scoreboard_entry_t din;
  logic              cf;
  logic              dack;
  logic              iv;
  scoreboard_entry_t iinstr;
  logic              icf;
  logic              iack;
  logic [2:0]        cnt;
  logic [2:0]        cfc;

  int total = 0;
  int bad   = 0;

  decoded_instr_queue #(
    .DEPTH    (DECODED_QUEUE_DEPTH),
    .CF_LIMIT (DECODED_QUEUE_CF_LIMIT)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .flush_i              (flush),
    .decoded_valid_i      (dv),
    .decoded_instr_i      (din),
    .is_ctrl_flow_i       (cf),
    .decoded_ack_o        (dack),
    .issue_valid_o        (iv),
    .issue_instr_o        (iinstr),
    .issue_is_ctrl_flow_o (icf),
    .issue_ack_i          (iack),
    .count_o              (cnt),
    .cf_count_o           (cfc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic scoreboard_entry_t mk(input logic [63:0] pc);
    scoreboard_entry_t e;
    e       = '0;
    e.pc    = pc;
    e.rd    = pc[6:2];
    e.fu    = FU_ALU;
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and checked at #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    dv    = 1'b1;
    din   = mk(64'h10);
    cf    = 1'b0;
    iack  = 1'b0;
    #2;
    chk("rst_ack",   64'(dack), 64'd0);
    chk("rst_valid", 64'(iv),   64'd0);
    chk("rst_count", 64'(cnt),  64'd0);
    chk("rst_cf",    64'(cfc),  64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ack", 64'(dack), 64'd1);
    dv = 1'b0;
    cyc();

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      dv  = 1'b1;
      cf  = 1'b0;
      din = mk(64'h8000_0000 + 64'(4 * i));
      #1;
      chk("fill_ack", 64'(dack), 64'd1);
      cyc();
      chk("fill_head", iinstr.pc, 64'h8000_0000);
    end
    din = mk(64'h8000_0010);
    #1;
    chk("full_count", 64'(cnt),  64'd4);
    chk("full_ack",   64'(dack), 64'd0);
    cyc();
    chk("full_hold", 64'(cnt), 64'd4);

    // Drain in order; full refuses even while popping.
    dv   = 1'b0;
    iack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc",  iinstr.pc, 64'h8000_0000 + 64'(4 * i));
      chk("drain_ack", 64'(dack), (i == 0) ? 64'd0 : 64'd1);
      cyc();
    end
    chk("drain_count", 64'(cnt), 64'd0);
    chk("drain_valid", 64'(iv),  64'd0);

    // Control-flow throttle.
    iack = 1'b0;
    dv   = 1'b1;
    cf   = 1'b1;
    din  = mk(64'h100);
    #1;
    chk("cf1_ack", 64'(dack), 64'd1);
    cyc();
    din = mk(64'h104);
    #1;
    chk("cf_count1", 64'(cfc),  64'd1);
    chk("cf2_ack",   64'(dack), 64'd0);
    cyc();
    chk("cf2_refused_cnt", 64'(cnt), 64'd1);
    cf  = 1'b0;
    din = mk(64'h108);
    #1;
    chk("noncf_ack", 64'(dack), 64'd1);
    cyc();
    chk("noncf_cnt", 64'(cnt), 64'd2);
    chk("noncf_cf",  64'(cfc), 64'd1);
    cf   = 1'b1;
    din  = mk(64'h104);
    iack = 1'b1;
    #1;
    chk("pop_br_pc",  iinstr.pc, 64'h100);
    chk("pop_br_cf",  64'(icf),  64'd1);
    chk("pop_br_ack", 64'(dack), 64'd0);
    cyc();
    chk("after_pop_cf", 64'(cfc),  64'd0);
    chk("reenable_ack", 64'(dack), 64'd1);
    chk("head_108",     iinstr.pc, 64'h108);
    cyc();
    chk("pushpop_cnt",  64'(cnt),  64'd1);
    chk("pushpop_cf",   64'(cfc),  64'd1);
    chk("head_104",     iinstr.pc, 64'h104);
    chk("head_104_cf",  64'(icf),  64'd1);

    // Flush priority with count=2.
    iack = 1'b0;
    cf   = 1'b0;
    din  = mk(64'h10C);
    cyc();
    chk("preflush_cnt", 64'(cnt), 64'd2);
    flush = 1'b1;
    iack  = 1'b1;
    #1;
    chk("flush_valid", 64'(iv),   64'd0);
    chk("flush_ack",   64'(dack), 64'd0);
    cyc();
    chk("flush_cnt", 64'(cnt), 64'd0);
    chk("flush_cf",  64'(cfc), 64'd0);
    cyc();
    chk("flush2_cnt", 64'(cnt), 64'd0);
    flush = 1'b0;
    dv    = 1'b0;
    iack  = 1'b0;
    #1;
    chk("postflush_valid", 64'(iv), 64'd0);

    // Steady stream of 10 with pointer wrap.
    dv  = 1'b1;
    cf  = 1'b0;
    din = mk(64'h300);
    cyc();
    iack = 1'b1;
    for (int k = 1; k < 10; k++) begin
      din = mk(64'h300 + 64'(4 * k));
      #1;
      chk("stream_valid", 64'(iv),   64'd1);
      chk("stream_pc",    iinstr.pc, 64'h300 + 64'(4 * (k - 1)));
      chk("stream_cnt",   64'(cnt),  64'd1);
      cyc();
    end
    dv = 1'b0;
    #1;
    chk("stream_last", iinstr.pc, 64'h324);
    cyc();
    chk("stream_empty", 64'(cnt), 64'd0);
    iack = 1'b0;

    // Asynchronous reset mid-operation with count=3.
    dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = mk(64'h400 + 64'(4 * i));
      cyc();
    end
    dv = 1'b0;
    chk("prereset_cnt", 64'(cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(iv),   64'd0);
    chk("async_cnt",   64'(cnt),  64'd0);
    chk("async_ack",   64'(dack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_cnt", 64'(cnt), 64'd0);

    // Push into an empty queue with issue_ack_i high.
    dv   = 1'b1;
    cf   = 1'b0;
    din  = mk(64'h200);
    iack = 1'b1;
    #1;
    chk("ft_ack", 64'(dack), 64'd1);
`ifdef DECODED_QUEUE_FALLTHROUGH_EN
    chk("ft_valid", 64'(iv),   64'd1);
    chk("ft_pc",    iinstr.pc, 64'h200);
    cyc();
    dv = 1'b0;
    #1;
    chk("ft_cnt", 64'(cnt), 64'd0);
`else
    chk("reg_valid0", 64'(iv), 64'd0);
    cyc();
    dv   = 1'b0;
    iack = 1'b0;
    #1;
    chk("reg_cnt",    64'(cnt),  64'd1);
    chk("reg_valid1", 64'(iv),   64'd1);
    chk("reg_pc",     iinstr.pc, 64'h200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoded_instr_queue.md
Name: decoded_instr_queue

Overview:
- Small FIFO of decoded instructions between the decoder (id_stage) and the issue stage (issue_stage / scoreboard).
- Upstream: stores one `scoreboard_entry_t` per accepted decoder output, together with its control-flow flag.
- Downstream: presents entries to issue with a valid/ack handshake.
- Throttles decode when too many unresolved control-flow instructions are queued, and drops all contents on flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CF_LIMIT, 1, max control-flow entries resident in queue at once; 1 <= CF_LIMIT <= DEPTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries (mispredict / exception).
- decoded_valid_i  in  1  decoder has an instruction.
- decoded_instr_i  in  scoreboard_entry_t  decoded instruction.
- is_ctrl_flow_i  in  1  decoded instruction is branch/jump.
- decoded_ack_o  out  1  queue accepts the instruction this cycle.
- issue_valid_o  out  1  head entry valid.
- issue_instr_o  out  scoreboard_entry_t  head entry.
- issue_is_ctrl_flow_o  out  1  head entry control-flow flag.
- issue_ack_i  in  1  issue consumes head this cycle.
- count_o  out  $clog2(DEPTH)+1  entries held.
- cf_count_o  out  $clog2(DEPTH)+1  control-flow entries held.

Behaviour:
- Reset (async assert, sync release):
  - read/write pointers, count_o and cf_count_o all 0; storage contents don't-care.
  - issue_valid_o=0; decoded_ack_o=0 while rst_ni low.
- Accept (push):
  - decoded_ack_o = !flush_i && count_o!=DEPTH && !(is_ctrl_flow_i && cf_count_o==CF_LIMIT).
  - No combinational path from issue_ack_i to decoded_ack_o; a full queue refuses even when popping the same cycle.
  - push = decoded_valid_i && decoded_ack_o. Entry is written at the write pointer; the write pointer increments modulo DEPTH (natural wrap).
- Output (pop):
  - issue_valid_o = (count_o!=0) && !flush_i.
  - issue_instr_o / issue_is_ctrl_flow_o are taken from the read pointer.
  - pop = issue_valid_o && issue_ack_i; the read pointer increments modulo DEPTH.
  - issue_ack_i with issue_valid_o=0 is ignored.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 at the earliest.
- Counters:
  - count_o next = count + push - pop. Simultaneous push and pop leaves the count unchanged.
  - cf_count_o next = cf + (push && is_ctrl_flow_i) - (pop && issue_is_ctrl_flow_o).
- Flush:
  - flush_i has priority over push and pop in the same cycle.
  - Next cycle: both pointers, count_o and cf_count_o are 0.
  - During the flush cycle, decoded_ack_o=0 and issue_valid_o=0.
  - Consecutive flush cycles keep the queue empty.
- Stability: while issue_valid_o=1 and issue_ack_i=0, issue outputs hold stable.
- Invariants, flagged by assertions:
  - cf_count_o <= count_o <= DEPTH.
  - cf_count_o <= CF_LIMIT.

Optional Feature:
- Macro DECODED_QUEUE_FALLTHROUGH_EN.
- Defined: when count_o==0 and push occurs, the output is driven combinationally from decoded_instr_i / is_ctrl_flow_i with issue_valid_o=1 in the same cycle (zero latency).
  - If issue_ack_i is also 1, the entry is consumed and not written; counters and pointers are unchanged.
  - Otherwise the entry is written as normal.
- Undefined: output is strictly registered; latency 1 as above.

Decomposition:
- Shared package (ariane_pkg): uses existing `scoreboard_entry_t`. Add constants DECODED_QUEUE_DEPTH=4 and DECODED_QUEUE_CF_LIMIT=1 for top-level instantiation.
- One natural sub-module: fifo_ptr_ctrl, which owns pointers, count, full/empty and flush clear. The data array and CF counter stay in decoded_instr_queue.

Test Plan:
- Reset checks: rst_ni low mid-operation with count=3 -> immediately issue_valid_o=0, count_o=0; after release, decoded_ack_o=1 for a non-CF instruction.
- Fill to full: push 4 non-CF entries (pc 0x80000000..0x8000000C) with issue_ack_i=0 -> count_o=4, decoded_ack_o=0. Drain in order -> pc 0x80000000 first; ack reasserts the cycle after the first pop.
- CF throttle: push branch (pc 0x100, is_ctrl_flow_i=1), then a second branch -> second refused, cf_count_o=1. A non-CF instruction is still accepted. Popping the first branch re-enables the second next cycle.
- Flush priority: count=2, assert flush_i with decoded_valid_i=1 and issue_ack_i=1 -> no push or pop in that cycle, issue_valid_o=0; next cycle count_o=0, cf_count_o=0.
- Simultaneous push/pop with pointer wrap: steady stream of 10 instructions with issue_ack_i=1 -> count_o stays 1, order preserved across pointer wrap.
- Fallthrough (macro defined): empty queue, push pc 0x200 with issue_ack_i=1 -> issue_valid_o=1 and issue_instr_o.pc=0x200 in the same cycle; count_o remains 0.
